// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mul_state_t;

    // Width of an iteration counter that must hold the value w.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/iter_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, signed or unsigned,
// valid/ready on both sides, optional early exit once the remaining multiplier bits are zero.
module iter_mul
    import mul_pkg::*;
#(
    parameter int W          = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic           mul_clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           is_signed,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           busy
);

    localparam int CW = cnt_w(W);

    mul_state_t    state;
    logic [W-1:0]  mcand;
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;   // unprocessed multiplier bits low, finished product bits high
    logic [CW-1:0] cnt;
    logic          neg;

    logic [W-1:0]   x_mag;
    logic [W-1:0]   y_mag;
    logic [W:0]     sum;
    logic [2*W-1:0] pair_next;
    logic [2*W-1:0] final_prod;
    logic [W-1:0]   rem_mask;
    logic           last;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        x_mag     = (is_signed && x[W-1]) ? -x : x;
        y_mag     = (is_signed && y[W-1]) ? -y : y;
        sum       = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};
        pair_next = {sum, acc_lo[W-1:1]};
        // After this cycle's shift, cnt-1 multiplier bits are still waiting at the bottom.
        rem_mask  = ~({W{1'b1}} << (cnt - CW'(1)));
        last      = (cnt == CW'(1));
        final_prod = pair_next;
        if (EARLY_EXIT) begin
            last       = last || ((pair_next[W-1:0] & rem_mask) == '0);
            final_prod = pair_next >> (cnt - CW'(1));
        end
    end

    // NOTE: the reset is synchronous and clears the datapath too, so an aborted
    // operation leaves no trace in result or the operand registers.
    always_ff @(posedge mul_clk) begin
        if (reset) begin
            state     <= IDLE;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= x_mag;
                        acc_lo   <= y_mag;
                        acc_hi   <= '0;
                        cnt      <= CW'(W);
                        neg      <= is_signed & (x[W-1] ^ y[W-1]);
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    {acc_hi, acc_lo} <= pair_next;
                    cnt              <= cnt - CW'(1);
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= neg ? -final_prod : final_prod;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mul.sv
// Randomised and directed bench for iter_mul across four width/early-exit configurations,
// checked against an arithmetic product and latency model.
module tb_iter_mul;

    logic mul_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 mul_clk = ~mul_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Per-configuration stimulus and response; operands are carried at the widest width.
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic        is_signed [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic        busy      [4];
    logic [65:0] x_v       [4];
    logic [65:0] y_v       [4];

    logic [63:0] res_a;
    logic [63:0] res_b;
    logic [15:0] res_c;
    logic [65:0] res_d;

    iter_mul #(.W(32), .EARLY_EXIT(1'b0)) u_w32 (
        .mul_clk(mul_clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .is_signed(is_signed[0]), .x(x_v[0][31:0]), .y(y_v[0][31:0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .result(res_a), .busy(busy[0]));

    iter_mul #(.W(32), .EARLY_EXIT(1'b1)) u_w32_ee (
        .mul_clk(mul_clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .is_signed(is_signed[1]), .x(x_v[1][31:0]), .y(y_v[1][31:0]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .result(res_b), .busy(busy[1]));

    iter_mul #(.W(8), .EARLY_EXIT(1'b0)) u_w8 (
        .mul_clk(mul_clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .is_signed(is_signed[2]), .x(x_v[2][7:0]), .y(y_v[2][7:0]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .result(res_c), .busy(busy[2]));

    iter_mul #(.W(33), .EARLY_EXIT(1'b1)) u_w33_ee (
        .mul_clk(mul_clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .is_signed(is_signed[3]), .x(x_v[3][32:0]), .y(y_v[3][32:0]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .result(res_d), .busy(busy[3]));

    function automatic int cfg_w(input int k);
        case (k)
            0, 1:    return 32;
            2:       return 8;
            default: return 33;
        endcase
    endfunction

    function automatic bit cfg_ee(input int k);
        return (k == 1) || (k == 3);
    endfunction

    function automatic logic [65:0] get_res(input int k);
        case (k)
            0:       return 66'(res_a);
            1:       return 66'(res_b);
            2:       return 66'(res_c);
            default: return res_d;
        endcase
    endfunction

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Golden product: interpret operands per mode, multiply wide, keep 2w bits.
    function automatic logic [65:0] ref_prod(input int w, input bit sgn,
                                             input logic [65:0] a, input logic [65:0] b);
        logic signed [131:0] sa;
        logic signed [131:0] sb;
        logic signed [131:0] p;
        logic [65:0]         m;
        sa = $signed(132'(a));
        sb = $signed(132'(b));
        if (sgn && a[w-1]) sa = sa - (132'sd1 <<< w);
        if (sgn && b[w-1]) sb = sb - (132'sd1 <<< w);
        p = sa * sb;
        m = (66'd1 << (2 * w)) - 66'd1;
        return 66'(p) & m;
    endfunction

    // Cycles from accept to first out_valid.
    function automatic int ref_lat(input int w, input bit ee, input bit sgn, input logic [65:0] b);
        logic [65:0] mag;
        int          hi;
        if (!ee) return w + 1;
        mag = (sgn && b[w-1]) ? ((66'd1 << w) - b) : b;
        hi  = 0;
        for (int i = 0; i < w; i++) if (mag[i]) hi = i;
        return hi + 2;
    endfunction

    function automatic logic [65:0] rnd_op(input int w);
        logic [65:0] v;
        logic [65:0] m;
        m = (66'd1 << w) - 66'd1;
        v = {2'($urandom), $urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = m;
            2:       v = 66'd1 << (w - 1);
            3, 4:    v = v >> $urandom_range(0, w - 1);
            default: ;
        endcase
        return v & m;
    endfunction

    // One full transaction with busy-time noise on in_valid and optional result backpressure.
    task automatic run_op(input int k, input bit sgn, input logic [65:0] a, input logic [65:0] b,
                          input int hold, input logic [65:0] exp_res, input int exp_lat);
        int lat;
        @(negedge mul_clk);
        check("in_ready_idle", 66'(in_ready[k]), 66'd1);
        in_valid[k]  = 1'b1;
        is_signed[k] = sgn;
        x_v[k]       = a;
        y_v[k]       = b;
        @(negedge mul_clk);
        check("busy_after_accept", 66'(busy[k]), 66'd1);
        check("in_ready_busy", 66'(in_ready[k]), 66'd0);
        lat = 1;
        while (!out_valid[k] && lat < 200) begin
            in_valid[k]  = 1'($urandom);
            is_signed[k] = 1'($urandom);
            x_v[k]       = {2'($urandom), $urandom, $urandom};
            y_v[k]       = {2'($urandom), $urandom, $urandom};
            @(negedge mul_clk);
            lat++;
        end
        check("latency", 66'(lat), 66'(exp_lat));
        check("result", get_res(k), exp_res);
        for (int h = 0; h < hold; h++) begin
            in_valid[k] = 1'($urandom);
            @(negedge mul_clk);
            check("bp_result", get_res(k), exp_res);
            check("bp_valid", 66'(out_valid[k]), 66'd1);
            check("bp_in_ready", 66'(in_ready[k]), 66'd0);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(negedge mul_clk);
        out_ready[k] = 1'b0;
        check("valid_after_hs", 66'(out_valid[k]), 66'd0);
        check("in_ready_after_hs", 66'(in_ready[k]), 66'd1);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            is_signed[k] = 1'b0;
            x_v[k]       = '0;
            y_v[k]       = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge mul_clk);
        for (int k = 0; k < 4; k++) begin
            check("rst_out_valid", 66'(out_valid[k]), 66'd0);
            check("rst_in_ready", 66'(in_ready[k]), 66'd1);
            check("rst_busy", 66'(busy[k]), 66'd0);
            check("rst_result", get_res(k), 66'd0);
        end
        reset = 1'b0;

        // Directed, W=32 full latency.
        run_op(0, 1'b0, 66'hFFFF_FFFF, 66'hFFFF_FFFF, 0, 66'hFFFF_FFFE_0000_0001, 33);
        run_op(0, 1'b1, 66'hFFFF_FFFF, 66'h3,         0, 66'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op(0, 1'b1, 66'h8000_0000, 66'h8000_0000, 0, 66'h4000_0000_0000_0000, 33);
        run_op(0, 1'b0, 66'h8000_0000, 66'h8000_0000, 5, 66'h4000_0000_0000_0000, 33);
        run_op(0, 1'b0, 66'h3,         66'h4,         0, 66'hC,                   33);

        // Abort an operation partway through CALC.
        @(negedge mul_clk);
        in_valid[0] = 1'b1;
        x_v[0]      = 66'h1234_5678;
        y_v[0]      = 66'h9ABC_DEF0;
        @(negedge mul_clk);
        in_valid[0] = 1'b0;
        repeat (9) @(negedge mul_clk);
        reset = 1'b1;
        @(negedge mul_clk);
        reset = 1'b0;
        check("abort_out_valid", 66'(out_valid[0]), 66'd0);
        check("abort_result", get_res(0), 66'd0);
        check("abort_in_ready", 66'(in_ready[0]), 66'd1);
        check("abort_busy", 66'(busy[0]), 66'd0);
        repeat (40) @(negedge mul_clk);
        check("abort_no_output", 66'(out_valid[0]), 66'd0);
        run_op(0, 1'b0, 66'd7, 66'd5, 0, 66'd35, 33);

        // Directed, W=32 early exit.
        run_op(1, 1'b0, 66'd7,   66'd5, 0, 66'd35, 4);
        run_op(1, 1'b0, 66'd123, 66'd0, 0, 66'd0,  2);
        run_op(1, 1'b1, 66'h8000_0000, 66'h8000_0000, 1, 66'h4000_0000_0000_0000, 33);

        // Randomised regression on every configuration.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 250; i++) begin
                int          w;
                bit          sgn;
                logic [65:0] a;
                logic [65:0] b;
                w   = cfg_w(k);
                sgn = 1'($urandom);
                a   = rnd_op(w);
                b   = rnd_op(w);
                repeat ($urandom_range(0, 2)) @(negedge mul_clk);
                run_op(k, sgn, a, b, $urandom_range(0, 2), ref_prod(w, sgn, a, b),
                       ref_lat(w, cfg_ee(k), sgn, b));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
